// File: rtl/mem_arbiter.sv
// mem_arbiter: fair fetch/LSU arbiter that sequences byte-wide RAM transfers and extends load data
module mem_arbiter #(
    parameter int                 ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  IO_BASE = 'h00030000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              Clear_flag,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_valid,
    input  logic              ls_store,
    input  logic [1:0]        ls_size,
    input  logic              ls_unsigned,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic              io_buffer_full,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din
);
    typedef enum logic [1:0] {IDLE, ADDR, TAIL, DONE} state_t;
    state_t            state_q, state_d;
    logic              last_data_q, last_data_d;
    logic              own_ls_q, own_ls_d;
    logic              store_q, store_d;
    logic              uns_q, uns_d;
    logic [1:0]        size_q, size_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic              flush, is_read, ls_ok, if_ok, grant_ls, capture;
    logic [1:0]        lane;
    logic [31:0]       word, ext;

    assign flush    = rdy && Clear_flag;
    assign is_read  = !(own_ls_q && store_q);
    // IO stores stall on a full buffer; during a flush only committed stores may start
    assign ls_ok    = ls_valid && (ls_store ? !(ls_addr >= IO_BASE && io_buffer_full) : !Clear_flag);
    assign if_ok    = if_valid && !Clear_flag;
    assign grant_ls = ls_ok && !(if_ok && last_data_q);
    assign capture  = (state_q == ADDR && cnt_q != 3'd0) || state_q == TAIL;
    assign lane     = 2'(cnt_q - 3'd1);

    always_comb begin
        word = buf_q;
        word[{lane, 3'b000} +: 8] = mem_din;
        ext = size_q == 2'd0 ? {{24{~uns_q & word[7]}}, word[7:0]} :
              size_q == 2'd1 ? {{16{~uns_q & word[15]}}, word[15:0]} : word;
    end

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        own_ls_d    = own_ls_q;
        store_d     = store_q;
        uns_d       = uns_q;
        size_d      = size_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = capture ? word : buf_q;
        if_data_d   = if_data_q;
        ls_rdata_d  = ls_rdata_q;
        if (state_q == IDLE && (ls_ok || if_ok)) begin
            state_d     = ADDR;
            cnt_d       = 3'd0;
            own_ls_d    = grant_ls;
            last_data_d = grant_ls;
            addr_d      = grant_ls ? ls_addr : if_addr;
            store_d     = grant_ls && ls_store;
            uns_d       = ls_unsigned;
            size_d      = grant_ls ? ls_size : 2'd2;
            n_d         = (!grant_ls || ls_size[1]) ? 3'd4 : (ls_size[0] ? 3'd2 : 3'd1);
            wdata_d     = ls_wdata;
        end
        if (state_q == ADDR) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == n_q - 3'd1)
                state_d = store_q ? DONE : TAIL;
        end
        if (state_q == TAIL) begin
            state_d = DONE;
            if (own_ls_q)
                ls_rdata_d = ext;
            else
                if_data_d = word;
        end
        if (state_q == DONE)
            state_d = IDLE;
        if (flush && is_read && state_q != IDLE)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            own_ls_q    <= 1'b0;
            store_q     <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'd0;
            n_q         <= 3'd0;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_data_q   <= '0;
            ls_rdata_q  <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            own_ls_q    <= own_ls_d;
            store_q     <= store_d;
            uns_q       <= uns_d;
            size_q      <= size_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign mem_wr   = rdy && state_q == ADDR && store_q;
    assign mem_a    = state_q == ADDR ? addr_q + ADDR_W'(cnt_q) : '0;
    assign mem_dout = (state_q == ADDR && store_q) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;
    assign if_done  = state_q == DONE && !own_ls_q && !flush;
    assign ls_done  = state_q == DONE && own_ls_q && !(flush && !store_q);
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario bench with a byte RAM model behind the arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        Clear_flag = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_valid = 1'b0;
    logic        ls_store = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic        ls_unsigned = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        io_buffer_full = 1'b0;
    logic        mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  ram [0:4095];
    int          n_tests = 0;
    int          n_fail = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .Clear_flag(Clear_flag),
        .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_valid(ls_valid), .ls_store(ls_store), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .io_buffer_full(io_buffer_full), .mem_wr(mem_wr), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                            input logic [31:0] exp, input int lat, input string name);
        ls_valid = 1'b1; ls_store = 1'b0; ls_size = size; ls_unsigned = uns; ls_addr = addr;
        for (int k = 1; k < lat; k++) begin
            cyc(); #1;
            n_tests++;
            if (ls_done !== 1'b0 || mem_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early done/wr at +%0d: done=%b wr=%b, want 0/0", name, k, ls_done, mem_wr);
            end
        end
        cyc(); #1;
        n_tests++;
        if (ls_done !== 1'b1 || ls_rdata !== exp) begin
            n_fail++;
            $display("FAIL %s done/data: done=%b data=%h, want 1/%h", name, ls_done, ls_rdata, exp);
        end
        ls_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({if_done, ls_done, mem_wr} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset strobes: got %b, want 000", {if_done, ls_done, mem_wr});
        end
        n_tests++;
        if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset data: if_data=%h ls_rdata=%h, want 0/0", if_data, ls_rdata);
        end
        n_tests++;
        if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            n_fail++;
            $display("FAIL reset mem bus: mem_a=%h mem_dout=%h, want 0/0", mem_a, mem_dout);
        end
    endtask

    task automatic test_fetch();
        if_addr = 32'h100; if_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            n_tests++;
            if (mem_a !== 32'h100 + i || mem_wr !== 1'b0 || if_done !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch addr byte %0d: mem_a=%h wr=%b done=%b, want %h/0/0", i, mem_a, mem_wr, if_done, 32'h100 + i);
            end
        end
        cyc(); #1;
        n_tests++;
        if (if_done !== 1'b0 || mem_a !== 32'h0) begin
            n_fail++;
            $display("FAIL fetch tail: done=%b mem_a=%h, want 0/0", if_done, mem_a);
        end
        cyc(); #1;
        n_tests++;
        if (if_done !== 1'b1 || if_data !== 32'h00500013) begin
            n_fail++;
            $display("FAIL fetch done: done=%b data=%h, want 1/00500013", if_done, if_data);
        end
        if_valid = 1'b0;
        cyc(); #1;
        n_tests++;
        if (if_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch single pulse: done=%b, want 0", if_done);
        end
    endtask

    task automatic test_load_byte();
        run_load(2'd0, 1'b0, 32'h200, 32'hFFFFFF80, 3, "lb_signed");
        run_load(2'd0, 1'b1, 32'h200, 32'h00000080, 3, "lbu");
        run_load(2'd1, 1'b0, 32'h200, 32'h00007F80, 4, "lh_pos");
        run_load(2'd1, 1'b0, 32'h202, 32'hFFFF8001, 4, "lh_neg");
        run_load(2'd1, 1'b1, 32'h202, 32'h00008001, 4, "lhu");
    endtask

    task automatic test_store_word();
        logic [7:0] exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ls_valid = 1'b1; ls_store = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            n_tests++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h300 + i || mem_dout !== exp_b[i] || ls_done !== 1'b0) begin
                n_fail++;
                $display("FAIL sw byte %0d: wr=%b a=%h d=%h done=%b, want 1/%h/%h/0", i, mem_wr, mem_a, mem_dout, ls_done, 32'h300 + i, exp_b[i]);
            end
        end
        cyc(); #1;
        n_tests++;
        if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL sw done: done=%b wr=%b, want 1/0", ls_done, mem_wr);
        end
        ls_valid = 1'b0; ls_store = 1'b0;
        cyc();
        run_load(2'd2, 1'b0, 32'h300, 32'hDEADBEEF, 6, "lw_readback");
        run_load(2'd3, 1'b0, 32'h300, 32'hDEADBEEF, 6, "lw_size3");
    endtask

    task automatic test_fair();
        int ls_cnt = 0, if_cnt = 0, wr_cnt = 0, ls_t1 = -1, ls_t2 = -1, if_t = -1;
        logic [31:0] ls_d = '0, if_d = '0;
        rst = 1'b1;
        if_addr = 32'h100; if_valid = 1'b1;
        ls_addr = 32'h300; ls_size = 2'd2; ls_store = 1'b0; ls_unsigned = 1'b0; ls_valid = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            cyc(); #1;
            if (mem_wr) wr_cnt++;
            if (ls_done) begin
                ls_cnt++;
                ls_d = ls_rdata;
                if (ls_t1 < 0) ls_t1 = k; else ls_t2 = k;
            end
            if (if_done) begin
                if_cnt++;
                if_t = k;
                if_d = if_data;
            end
        end
        n_tests++;
        if (ls_cnt != 2 || ls_t1 != 6 || ls_t2 != 20) begin
            n_fail++;
            $display("FAIL fair lsu: count=%0d at %0d,%0d, want 2 at 6,20", ls_cnt, ls_t1, ls_t2);
        end
        n_tests++;
        if (if_cnt != 1 || if_t != 13) begin
            n_fail++;
            $display("FAIL fair fetch: count=%0d at %0d, want 1 at 13", if_cnt, if_t);
        end
        n_tests++;
        if (wr_cnt != 0) begin
            n_fail++;
            $display("FAIL fair no write: writes=%0d, want 0", wr_cnt);
        end
        n_tests++;
        if (ls_d !== 32'hDEADBEEF || if_d !== 32'h00500013) begin
            n_fail++;
            $display("FAIL fair data: ls=%h if=%h, want deadbeef/00500013", ls_d, if_d);
        end
        if_valid = 1'b0; ls_valid = 1'b0; Clear_flag = 1'b1;
        cyc();
        Clear_flag = 1'b0;
        cyc();
    endtask

    task automatic test_io_store();
        int wr_cnt = 0;
        ls_valid = 1'b1; ls_store = 1'b1; ls_size = 2'd0; ls_addr = 32'h00030000; ls_wdata = 32'h000000A5;
        for (int k = 0; k <= 10; k++) begin
            io_buffer_full = (k < 10);
            #1;
            if (mem_wr) wr_cnt++;
            cyc();
        end
        n_tests++;
        if (wr_cnt != 0) begin
            n_fail++;
            $display("FAIL io stall: writes=%0d, want 0", wr_cnt);
        end
        #1;
        n_tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h00030000 || mem_dout !== 8'hA5) begin
            n_fail++;
            $display("FAIL io write: wr=%b a=%h d=%h, want 1/00030000/a5", mem_wr, mem_a, mem_dout);
        end
        cyc(); #1;
        n_tests++;
        if (ls_done !== 1'b1) begin
            n_fail++;
            $display("FAIL io done: done=%b, want 1", ls_done);
        end
        ls_valid = 1'b0; ls_store = 1'b0;
        cyc();
    endtask

    task automatic test_flush();
        int bad = 0;
        ls_valid = 1'b1; ls_store = 1'b0; ls_size = 2'd2; ls_addr = 32'h300;
        cyc(); cyc(); cyc();
        Clear_flag = 1'b1; ls_valid = 1'b0;
        #1;
        n_tests++;
        if (mem_a !== 32'h302) begin
            n_fail++;
            $display("FAIL flush pre: mem_a=%h, want 00000302", mem_a);
        end
        cyc();
        Clear_flag = 1'b0;
        #1;
        n_tests++;
        if (mem_a !== 32'h0) begin
            n_fail++;
            $display("FAIL flush idle: mem_a=%h, want 0", mem_a);
        end
        for (int k = 0; k < 5; k++) begin
            if (ls_done) bad++;
            cyc();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL flush load no done: pulses=%0d, want 0", bad);
        end
        if_addr = 32'h100; if_valid = 1'b1;
        repeat (6) cyc();
        Clear_flag = 1'b1; if_valid = 1'b0;
        #1;
        n_tests++;
        if (if_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush done gate: if_done=%b, want 0", if_done);
        end
        cyc();
        Clear_flag = 1'b0;
        #1;
        n_tests++;
        if (if_done !== 1'b0 || mem_a !== 32'h0) begin
            n_fail++;
            $display("FAIL flush after gate: if_done=%b mem_a=%h, want 0/0", if_done, mem_a);
        end
        cyc();
        ls_valid = 1'b1; ls_store = 1'b1; ls_size = 2'd2; ls_addr = 32'h310; ls_wdata = 32'h11223344;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            Clear_flag = (k == 2);
            #1;
            n_tests++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h310 + k - 1) begin
                n_fail++;
                $display("FAIL flush store byte %0d: wr=%b a=%h, want 1/%h", k - 1, mem_wr, mem_a, 32'h310 + k - 1);
            end
        end
        n_tests++;
        if (mem_dout !== 8'h11) begin
            n_fail++;
            $display("FAIL flush store last: mem_dout=%h, want 11", mem_dout);
        end
        cyc(); #1;
        n_tests++;
        if (ls_done !== 1'b1) begin
            n_fail++;
            $display("FAIL flush store done: done=%b, want 1", ls_done);
        end
        ls_valid = 1'b0; ls_store = 1'b0;
        cyc();
        run_load(2'd2, 1'b0, 32'h310, 32'h11223344, 6, "flush_store_readback");
    endtask

    task automatic test_rdy();
        ls_valid = 1'b1; ls_store = 1'b1; ls_size = 2'd1; ls_addr = 32'h330; ls_wdata = 32'h0000CAFE;
        cyc(); #1;
        n_tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h330 || mem_dout !== 8'hFE) begin
            n_fail++;
            $display("FAIL rdy first: wr=%b a=%h d=%h, want 1/330/fe", mem_wr, mem_a, mem_dout);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            rdy = 1'b0;
            #1;
            n_tests++;
            if (mem_wr !== 1'b0 || mem_a !== 32'h331) begin
                n_fail++;
                $display("FAIL rdy frozen %0d: wr=%b a=%h, want 0/331", k, mem_wr, mem_a);
            end
        end
        cyc();
        rdy = 1'b1;
        #1;
        n_tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h331 || mem_dout !== 8'hCA) begin
            n_fail++;
            $display("FAIL rdy resume: wr=%b a=%h d=%h, want 1/331/ca", mem_wr, mem_a, mem_dout);
        end
        cyc(); #1;
        n_tests++;
        if (ls_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rdy done: done=%b, want 1", ls_done);
        end
        ls_valid = 1'b0; ls_store = 1'b0;
        cyc();
        run_load(2'd1, 1'b1, 32'h330, 32'h0000CAFE, 4, "rdy_readback");
    endtask

    task automatic test_reset_mid();
        int wr = 0, dn = 0;
        ls_valid = 1'b1; ls_store = 1'b1; ls_size = 2'd2; ls_addr = 32'h320; ls_wdata = 32'h55667788;
        cyc(); cyc();
        rst = 1'b1; ls_valid = 1'b0;
        #1;
        n_tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h321) begin
            n_fail++;
            $display("FAIL reset mid pre: wr=%b a=%h, want 1/321", mem_wr, mem_a);
        end
        cyc();
        rst = 1'b0; ls_store = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (mem_wr) wr++;
            if (ls_done) dn++;
            cyc();
        end
        n_tests++;
        if (wr != 0 || dn != 0) begin
            n_fail++;
            $display("FAIL reset mid abort: writes=%0d dones=%0d, want 0/0", wr, dn);
        end
    endtask

    task automatic test_wrap();
        ram[12'hFFF] = 8'h34;
        ram[12'h000] = 8'h92;
        run_load(2'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFF9234, 4, "lh_wrap");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h00; ram[12'h102] = 8'h50; ram[12'h103] = 8'h00;
        ram[12'h200] = 8'h80; ram[12'h201] = 8'h7F; ram[12'h202] = 8'h01; ram[12'h203] = 8'h80;
        test_reset();
        test_fetch();
        test_load_byte();
        test_store_word();
        test_fair();
        test_io_store();
        test_flush();
        test_rdy();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between two requesters: the instruction fetch requester and the load/store unit (LSU).
- Arbitrates fairly between them, sequences multi-byte transfers one byte per cycle, and sign- or zero-extends load data.
- Holds committed stores while the IO buffer is full, and discards speculative reads on a pipeline flush.
- Sits between the instruction queue / store-load buffer and the RAM top-level pins.

Parameters:
IO_BASE, 32'h00030000, addresses >= IO_BASE are IO; IO stores obey io_buffer_full
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low = freeze all state
Clear_flag  in  1  pipeline flush
if_valid  in  1  fetch request, level, held until if_done
if_addr  in  32  fetch byte address (word fetch, 4 bytes)
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word, little-endian
ls_valid  in  1  LSU request, level, held until ls_done
ls_store  in  1  1 = store, 0 = load
ls_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
ls_unsigned  in  1  load zero-extend (LBU/LHU)
ls_addr  in  32  byte address, no alignment requirement
ls_wdata  in  32  store data; low bytes used
ls_done  out  1  one-cycle pulse; load data valid / store complete
ls_rdata  out  32  extended load result
io_buffer_full  in  1  IO sink cannot accept a write
mem_wr  out  1  1 = write
mem_a  out  32  RAM byte address
mem_dout  out  8  RAM write data
mem_din  in  8  RAM read data, valid one cycle after its address

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, last_data=0, byte counters 0, if_done=0, ls_done=0, if_data=0, ls_rdata=0, mem_wr=0, mem_a=0, mem_dout=0. Reset mid-transfer aborts it silently; no done pulse.
- rdy=0: no register changes, mem_wr forced 0 (no duplicated write), done outputs hold.
- Outside ADDR and WR, mem_wr=0 and mem_a=0.
- States: IDLE, ADDR (issue bytes), TAIL (capture last read byte), DONE (pulse).
- Grant in IDLE at cycle T:
  - Only one requester valid: grant it.
  - Both valid: grant ifetch if last_data=1, else grant LSU. last_data records the most recent grant.
  - Exception: an LSU store to an IO address while io_buffer_full=1 is not grantable. Fetch may be granted instead; otherwise stay IDLE.
- Payload (addr, size, store, wdata, unsigned) is latched at grant. Later changes are ignored.
- Byte count n: fetch = 4; LSU = 1/2/4 for size 0/1/2.
- Reads (fetch, load):
  - ADDR in cycles T+1..T+n: mem_a = addr+i for byte i.
  - mem_din captured at end of cycles T+2..T+n+1 into byte lane i; TAIL occupies T+n+1.
  - DONE at T+n+2: done=1 with data.
  - Latency: word = 6 cycles grant-to-done, byte = 3.
- Stores:
  - Cycles T+1..T+n: mem_wr=1, mem_a = addr+i, mem_dout = wdata[8i+7:8i].
  - DONE (ls_done=1) at T+n+1.
- Load extension: byte/half sign-extend from bit 7/15 unless ls_unsigned. Word is passed through.
- DONE returns to IDLE next cycle. The requester drops valid at the edge ending the done cycle. Valid high in DONE+1 is a new request; one IDLE cycle always separates transfers.
- Clear_flag=1 (with rdy=1):
  - An in-flight fetch or load returns to IDLE next cycle, with no done pulse. This includes a DONE-state pulse not yet driven.
  - An in-flight store continues to completion, since stores are committed.
  - In IDLE, only a store may be granted during a flush cycle.
- Clear_flag with a read in the DONE state: the done pulse in that same cycle is suppressed (combinationally gated).
- Address arithmetic wraps modulo 2^32.

Test Plan:
- Fetch only: RAM[0x100..0x103]=13,00,50,00, if_valid at T -> mem_a=0x100..0x103 at T+1..T+4, if_done at T+6, if_data=0x00500013.
- Load byte signed and unsigned at 0x200 with RAM=0x80 -> ls_done at T+3, ls_rdata=0xFFFFFF80 (signed) / 0x00000080 (unsigned).
- Store word 0xDEADBEEF to 0x300 -> mem_wr=1 T+1..T+4, mem_dout EF,BE,AD,DE at 0x300..0x303, ls_done T+5; then LW 0x300 returns 0xDEADBEEF.
- Fetch and load both valid continuously from reset:
  - Grants alternate LSU, fetch, LSU.
  - No write occurs during reads.
  - Each done asserts exactly once.
- IO store to 0x30000 with io_buffer_full=1 for 10 cycles while fetch is idle:
  - No mem_wr while io_buffer_full=1.
  - Write occurs at the cycle after io_buffer_full falls, +1.
- Clear_flag during word load at T+3 -> no ls_done, IDLE at T+4. Clear_flag during store at T+2 -> store completes, ls_done T+5. rst at T+2 of store -> no further writes.
